// File: rtl/freqmeter_pkg.sv
// Shared types and defaults for the frequency-meter result reader.
// Holds the bus address type, parameter defaults and FSM state encoding.
package freqmeter_pkg;

    typedef logic [10:0] addr_t;

    localparam int    N_CH_DEF       = 24;
    localparam addr_t STATUS_ADR_DEF = 11'h7FF;
    localparam addr_t RES_BASE_DEF   = 11'h000;
    localparam int    TIMEOUT_DEF    = 255;

    typedef enum logic [2:0] {
        IDLE,
        RD_STAT,
        SCAN,
        RD_RES,
        PUSH,
        WR_CLR
    } state_t;

endpackage

// File: rtl/freqmeter_reader_if.sv
// Wishbone classic bus between the reader (master) and the freqmeter slave.
// Signal names follow the master's point of view.
interface freqmeter_reader_if;
    import freqmeter_pkg::*;

    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    addr_t       adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;

    modport master (
        output cyc_o,
        output stb_o,
        output we_o,
        output adr_o,
        output dat_o,
        input  dat_i,
        input  ack_i
    );

    modport slave (
        input  cyc_o,
        input  stb_o,
        input  we_o,
        input  adr_o,
        input  dat_o,
        output dat_i,
        output ack_i
    );

endinterface

// File: rtl/freqmeter_chan_scan.sv
// Combinational lowest-set-bit finder over the pending-channel mask.
// Returns the index of the lowest set bit and whether any bit is set.
module freqmeter_chan_scan #(
    parameter int N_CH = 24
) (
    input  logic [N_CH-1:0] i_mask,
    output logic [4:0]      o_idx,
    output logic            o_any
);

    always_comb begin
        o_idx = 5'd0;
        // Walk downward so the lowest set bit wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = 5'(i);
            end
        end
    end

    assign o_any = |i_mask;

endmodule

// File: rtl/freqmeter_reader.sv
// Interrupt-driven reader: fetches ready mask, streams each channel result, clears.
// Define FREQMETER_READER_TIMEOUT_EN to enable the bus ack watchdog and err_o.
module freqmeter_reader
    import freqmeter_pkg::*;
#(
    parameter int    N_CH       = N_CH_DEF,
    parameter addr_t STATUS_ADR = STATUS_ADR_DEF,
    parameter addr_t RES_BASE   = RES_BASE_DEF,
    parameter int    TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    freqmeter_reader_if.master bus,
    input  logic        inta_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [4:0]  res_chan_o,
    output logic [31:0] res_data_o,
    output logic        err_o
);

    if (N_CH < 1 || N_CH > 32 || TIMEOUT < 1) begin : g_param_chk
        $error("freqmeter_reader: parameter out of range");
    end

    state_t          r_state;
    logic            r_cyc;
    logic            r_we;
    addr_t           r_adr;
    logic [31:0]     r_dat;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] r_clear;
    logic [4:0]      r_sel;
    logic            r_valid;
    logic [4:0]      r_chan;
    logic [31:0]     r_data;

    logic            w_ack;
    logic            w_tmo;
    logic [N_CH-1:0] w_mask;
    logic [N_CH-1:0] w_onehot;
    logic [4:0]      w_idx;
    logic            w_any;

    // An ack only counts while our own cycle is open.
    assign w_ack    = r_cyc & bus.ack_i;
    assign w_mask   = bus.dat_i[N_CH-1:0];
    assign w_onehot = N_CH'(1) << r_sel;

    freqmeter_chan_scan #(
        .N_CH (N_CH)
    ) u_scan (
        .i_mask (r_pending),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

`ifdef FREQMETER_READER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_err;

    assign w_tmo = r_cyc & ~bus.ack_i & (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_tmo;
            if (r_cyc && !bus.ack_i && !w_tmo) begin
                r_wd <= r_wd + 1'b1;
            end else begin
                r_wd <= '0;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_tmo = 1'b0;
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_pending <= '0;
            r_clear   <= '0;
            r_sel     <= '0;
            r_valid   <= 1'b0;
            r_chan    <= '0;
            r_data    <= '0;
        end else if (w_tmo) begin
            // Abandon the whole batch; the slave keeps its ready bits.
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_pending <= '0;
            r_clear   <= '0;
            r_state   <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (inta_i) begin
                        r_cyc   <= 1'b1;
                        r_we    <= 1'b0;
                        r_adr   <= STATUS_ADR;
                        r_state <= RD_STAT;
                    end
                end
                RD_STAT: begin
                    if (w_ack) begin
                        r_cyc     <= 1'b0;
                        r_pending <= w_mask;
                        r_clear   <= w_mask;
                        r_state   <= (w_mask == '0) ? IDLE : SCAN;
                    end
                end
                SCAN: begin
                    r_cyc <= 1'b1;
                    if (w_any) begin
                        r_sel   <= w_idx;
                        r_we    <= 1'b0;
                        r_adr   <= RES_BASE + addr_t'(w_idx);
                        r_state <= RD_RES;
                    end else begin
                        r_we    <= 1'b1;
                        r_adr   <= STATUS_ADR;
                        r_dat   <= 32'(r_clear);
                        r_state <= WR_CLR;
                    end
                end
                RD_RES: begin
                    if (w_ack) begin
                        r_cyc     <= 1'b0;
                        r_data    <= bus.dat_i;
                        r_chan    <= r_sel;
                        r_pending <= r_pending & ~w_onehot;
                        r_valid   <= 1'b1;
                        r_state   <= PUSH;
                    end
                end
                PUSH: begin
                    if (res_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= SCAN;
                    end
                end
                WR_CLR: begin
                    if (w_ack) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cyc_o   = r_cyc;
    assign bus.stb_o   = r_cyc;
    assign bus.we_o    = r_we;
    assign bus.adr_o   = r_adr;
    assign bus.dat_o   = r_dat;
    assign res_valid_o = r_valid;
    assign res_chan_o  = r_chan;
    assign res_data_o  = r_data;

endmodule

// File: tb/tb_freqmeter_reader.sv
// Bench for freqmeter_reader: Wishbone slave model, result sink, reference model.
// Define FREQMETER_READER_TIMEOUT_EN here too to exercise the watchdog.
module tb_freqmeter_reader;
    import freqmeter_pkg::*;

    localparam int    NCH   = 24;
    localparam addr_t SADR  = 11'h7FF;
    localparam addr_t RBASE = 11'h000;
    localparam int    TMO   = 255;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        inta_i = 1'b0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [4:0]  res_chan_o;
    logic [31:0] res_data_o;
    logic        err_o;

    freqmeter_reader_if wb();

    always #5 clk_i = ~clk_i;

    freqmeter_reader #(
        .N_CH       (NCH),
        .STATUS_ADR (SADR),
        .RES_BASE   (RBASE),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (wb),
        .inta_i      (inta_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_chan_o  (res_chan_o),
        .res_data_o  (res_data_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic        we;
        addr_t       adr;
        logic [31:0] dat;
    } op_t;

    typedef struct {
        logic [4:0]  ch;
        logic [31:0] d;
    } res_t;

    typedef struct {
        logic [31:0] st;
        int          lat;
        int          stall;
        logic [31:0] exp_clr;
        int          exp_n;
    } vec_t;

    op_t  ops[$];
    op_t  eops[$];
    res_t got[$];
    res_t egot[$];

    logic [31:0] status = '0;
    logic [31:0] res_mem[32];
    int lat = 1;
    int stall = 0;
    bit no_ack = 0;
    bit hold_ready = 0;
    bit own_ack = 0;
    bit mon_en = 1;
    int wcnt = 0;
    int proto_err = 0;
    int err_cnt = 0;
    int cyc_cnt = 0;
    int checks = 0;
    int errors = 0;

    logic        p_cyc = 0, p_ack = 0, p_we = 0;
    logic        p_valid = 0, p_ready = 0;
    addr_t       p_adr = '0;
    logic [31:0] p_dat = '0, p_data = '0;
    logic [4:0]  p_chan = '0;

    // Slave, sink and protocol monitor all act on the falling edge.
    always @(negedge clk_i) begin
        if (mon_en && rst_ni) begin
            if (p_cyc && !p_ack && wb.cyc_o &&
                (wb.adr_o !== p_adr || wb.we_o !== p_we || wb.dat_o !== p_dat))
                proto_err++;
            if (p_ack && wb.cyc_o) proto_err++;
            if (wb.cyc_o !== wb.stb_o) proto_err++;
            if (res_valid_o && wb.cyc_o) proto_err++;
            if (p_valid && !p_ready &&
                (!res_valid_o || res_chan_o !== p_chan || res_data_o !== p_data))
                proto_err++;
        end
        if (err_o) err_cnt++;
        if (wb.cyc_o) cyc_cnt++;
        if (!own_ack) begin
            if (wb.ack_i) begin
                wb.ack_i = 1'b0;
                wcnt = 0;
            end else if (wb.cyc_o && wb.stb_o && !no_ack) begin
                wcnt++;
                if (wcnt >= lat) begin
                    ops.push_back('{wb.we_o, wb.adr_o, wb.dat_o});
                    if (!wb.we_o) begin
                        if (wb.adr_o == SADR) wb.dat_i = status;
                        else wb.dat_i = res_mem[5'(wb.adr_o - RBASE)];
                    end
                    wb.ack_i = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
        res_ready_i = hold_ready ? 1'b0 : ($urandom_range(99) >= stall);
        if (res_valid_o && res_ready_i) got.push_back('{res_chan_o, res_data_o});
        p_cyc   = wb.cyc_o;
        p_ack   = wb.ack_i;
        p_we    = wb.we_o;
        p_adr   = wb.adr_o;
        p_dat   = wb.dat_o;
        p_valid = res_valid_o;
        p_ready = res_ready_i;
        p_chan  = res_chan_o;
        p_data  = res_data_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic start_txn(input string nm);
        int n;
        n = 0;
        inta_i = 1'b1;
        do begin
            tick();
            n++;
        end while (!wb.cyc_o && n < 20);
        chk({nm, "_start"}, wb.cyc_o, 1);
        inta_i = 1'b0;
    endtask

    task automatic wait_quiet(input string nm);
        int q, n;
        q = 0;
        n = 0;
        while (q < 4 && n < 5000) begin
            tick();
            n++;
            if (wb.cyc_o || res_valid_o) q = 0;
            else q++;
        end
        checks++;
        if (q < 4) begin
            errors++;
            $display("FAIL %s_quiet: still busy after %0d cycles, required idle", nm, n);
        end
    endtask

    // Expected bus traffic and stream, straight from the status word.
    task automatic model(input logic [31:0] st);
        logic [63:0] full;
        logic [31:0] m;
        full = (64'd1 << NCH) - 64'd1;
        m = st & full[31:0];
        eops.delete();
        egot.delete();
        eops.push_back('{1'b0, SADR, 32'h0});
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                eops.push_back('{1'b0, RBASE + addr_t'(c), 32'h0});
                egot.push_back('{5'(c), res_mem[c]});
            end
        end
        if (m != 0) eops.push_back('{1'b1, SADR, m});
    endtask

    task automatic compare(input string nm);
        chk({nm, "_nres"}, got.size(), egot.size());
        for (int i = 0; i < got.size() && i < egot.size(); i++) begin
            chk({nm, "_chan"}, got[i].ch, egot[i].ch);
            chk({nm, "_data"}, got[i].d, egot[i].d);
        end
        chk({nm, "_nops"}, ops.size(), eops.size());
        for (int i = 0; i < ops.size() && i < eops.size(); i++) begin
            chk({nm, "_adr"}, ops[i].adr, eops[i].adr);
            chk({nm, "_we"}, ops[i].we, eops[i].we);
            if (eops[i].we) chk({nm, "_wdat"}, ops[i].dat, eops[i].dat);
        end
        chk({nm, "_proto"}, proto_err, 0);
        proto_err = 0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) res_mem[i] = $urandom;
    endtask

    task automatic run_txn(input string nm, input logic [31:0] st,
                           input int l, input int s);
        status = st;
        lat = l;
        stall = s;
        fill_mem();
        ops.delete();
        got.delete();
        start_txn(nm);
        wait_quiet(nm);
        model(st);
        compare(nm);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_cyc"}, wb.cyc_o, 0);
        chk({nm, "_stb"}, wb.stb_o, 0);
        chk({nm, "_we"}, wb.we_o, 0);
        chk({nm, "_adr"}, wb.adr_o, 0);
        chk({nm, "_dat"}, wb.dat_o, 0);
        chk({nm, "_valid"}, res_valid_o, 0);
        chk({nm, "_chan"}, res_chan_o, 0);
        chk({nm, "_rdata"}, res_data_o, 0);
        chk({nm, "_err"}, err_o, 0);
    endtask

    vec_t vt[7];

    initial begin
        int n, g, nw;
        bit found;
        vt[0] = '{32'h0000_0005, 1, 0,  32'h0000_0005, 2};
        vt[1] = '{32'h0000_0000, 1, 0,  32'h0000_0000, 0};
        vt[2] = '{32'hFFFF_FFFF, 1, 0,  32'h00FF_FFFF, 24};
        vt[3] = '{32'h8080_0001, 3, 40, 32'h0080_0001, 2};
        vt[4] = '{32'hFF00_0000, 2, 0,  32'h0000_0000, 0};
        vt[5] = '{32'h0000_0001, 4, 70, 32'h0000_0001, 1};
        vt[6] = '{32'h00A5_A5A5, 2, 30, 32'h00A5_A5A5, 12};
        wb.ack_i = 1'b0;
        wb.dat_i = '0;
        fill_mem();

        repeat (3) tick();
        chk_zero("reset");
        rst_ni = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vt[i].st, vt[i].lat, vt[i].stall);
            chk($sformatf("vec%0d_tabn", i), got.size(), vt[i].exp_n);
            nw = 0;
            foreach (ops[k]) if (ops[k].we) nw++;
            chk($sformatf("vec%0d_nwr", i), nw, (vt[i].exp_n > 0) ? 1 : 0);
            if (vt[i].exp_n > 0 && ops.size() > 0)
                chk($sformatf("vec%0d_clr", i), ops[ops.size()-1].dat, vt[i].exp_clr);
        end

        for (int i = 0; i < 20; i++) begin
            logic [31:0] st;
            st = $urandom;
            if (i % 3 == 0) st = st & $urandom & $urandom;
            run_txn($sformatf("rnd%0d", i), st, $urandom_range(1, 4), $urandom_range(0, 60));
        end

        // Stalled sink: result must sit still and the bus must stay quiet.
        status = 32'h4;
        lat = 2;
        stall = 0;
        fill_mem();
        ops.delete();
        got.delete();
        hold_ready = 1;
        start_txn("bp");
        n = 0;
        while (!res_valid_o && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", res_valid_o, 1);
            chk("bp_chan", res_chan_o, 2);
            chk("bp_data", res_data_o, res_mem[2]);
            chk("bp_cyc", wb.cyc_o, 0);
            tick();
        end
        hold_ready = 0;
        wait_quiet("bp");
        model(32'h4);
        compare("bp");

        // inta held high through the clear restarts after one idle cycle.
        status = 32'h1;
        lat = 1;
        fill_mem();
        ops.delete();
        got.delete();
        inta_i = 1'b1;
        found = 0;
        n = 0;
        while (!found && n < 200) begin
            tick();
            n++;
            foreach (ops[k]) if (ops[k].we) found = 1;
        end
        chk("reint_wr", found, 1);
        g = 0;
        do begin
            tick();
            if (!wb.cyc_o) g++;
        end while (!wb.cyc_o && g < 10);
        chk("reint_gap", g, 1);
        inta_i = 1'b0;
        wait_quiet("reint");
        nw = 0;
        foreach (ops[k]) if (ops[k].we) nw++;
        chk("reint_nwr", nw, 2);
        chk("reint_nres", got.size(), 2);
        proto_err = 0;

        // Stray ack with no cycle open must be ignored.
        got.delete();
        own_ack = 1;
        tick();
        wb.dat_i = 32'hFFFF_FFFF;
        wb.ack_i = 1'b1;
        tick();
        wb.ack_i = 1'b0;
        own_ack = 0;
        cyc_cnt = 0;
        repeat (5) tick();
        chk("stray_cyc", cyc_cnt, 0);
        chk("stray_nres", got.size(), 0);

        chk("no_err", err_cnt, 0);

`ifdef FREQMETER_READER_TIMEOUT_EN
        ops.delete();
        status = 32'h3;
        no_ack = 1;
        err_cnt = 0;
        cyc_cnt = 0;
        start_txn("tmo");
        n = 0;
        while (wb.cyc_o && n < 400) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("tmo_cyc_len", cyc_cnt, TMO);
        chk("tmo_err_pulse", err_cnt, 1);
        chk("tmo_cyc_off", wb.cyc_o, 0);
        chk("tmo_nops", ops.size(), 0);
        no_ack = 0;
        run_txn("after_tmo", 32'h0000_0006, 1, 0);
`endif

        // Reset in the middle of a result read.
        status = 32'h1;
        lat = 3;
        fill_mem();
        ops.delete();
        got.delete();
        start_txn("rst");
        n = 0;
        while (!(wb.cyc_o && !wb.we_o && wb.adr_o != SADR) && n < 50) begin
            tick();
            n++;
        end
        chk("rst_in_rdres", wb.adr_o, RBASE);
        no_ack = 1;
        mon_en = 0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (3) tick();
        rst_ni = 1'b1;
        no_ack = 0;
        cyc_cnt = 0;
        ops.delete();
        repeat (10) tick();
        chk("rst_after_cyc", cyc_cnt, 0);
        chk("rst_after_ops", ops.size(), 0);
        chk("rst_after_valid", res_valid_o, 0);
        proto_err = 0;
        mon_en = 1;
        run_txn("post_rst", 32'h0000_0081, 2, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freqmeter_reader.md
FREQMETER_READER -- requirements
Module: freqmeter_reader

Interface
REQ-001 SHALL have parameter N_CH, default 24, number of frequency-meter channels (1..32).
REQ-002 SHALL have parameter STATUS_ADR, default 11'h7FF, word address of the ready-mask/clear register.
REQ-003 SHALL have parameter RES_BASE, default 11'h000, word address of channel 0 result; channel c at RES_BASE+c.
REQ-004 SHALL have parameter TIMEOUT, default 255, ack watchdog limit in clk_i cycles.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports cyc_o/stb_o/we_o (output, 1), adr_o (output, 11), dat_o (output, 32): Wishbone classic master request.
REQ-008 SHALL have ports dat_i (input, 32) and ack_i (input, 1): Wishbone response.
REQ-009 SHALL have port inta_i, input, 1, level interrupt from the freqmeter slave.
REQ-010 SHALL have ports res_valid_o (output, 1), res_ready_i (input, 1), res_chan_o (output, 5), res_data_o (output, 32): result stream.
REQ-011 SHALL have port err_o, output, 1, one-cycle pulse on bus timeout (macro-dependent).

Function
REQ-012 SHALL implement FSM states IDLE, RD_STAT, SCAN, RD_RES, PUSH, WR_CLR.
REQ-013 IDLE: inta_i=1 -> RD_STAT next cycle; otherwise stay.
REQ-014 Bus access: cyc_o=stb_o=1 with stable adr_o/we_o/dat_o until ack_i sampled 1; cyc_o/stb_o drop the cycle after; no back-to-back: at least one idle cycle between accesses.
REQ-015 RD_STAT: read STATUS_ADR; on ack capture dat_i[N_CH-1:0] into pending and clear_mask; mask==0 -> IDLE (spurious), else SCAN.
REQ-016 SCAN: select lowest set bit of pending in one cycle -> RD_RES; pending==0 -> WR_CLR.
REQ-017 RD_RES: read RES_BASE+chan; on ack latch dat_i into res_data_o, chan into res_chan_o, clear that pending bit -> PUSH.
REQ-018 PUSH: res_valid_o=1, res_chan_o/res_data_o held stable until res_ready_i=1; transfer completes that cycle -> SCAN next cycle; no bus access during PUSH.
REQ-019 WR_CLR: write clear_mask (zero-extended) to STATUS_ADR, we_o=1; on ack -> IDLE.
REQ-020 Channels SHALL be emitted in ascending index order, each exactly once per status read.
REQ-021 ack_i while cyc_o=0 SHALL be ignored; inta_i changes outside IDLE SHALL be ignored.
REQ-022 inta_i still high after WR_CLR SHALL start a new RD_STAT one cycle after returning to IDLE.
REQ-023 Status bits above N_CH-1 SHALL be discarded.

Reset
REQ-024 rst_ni=0 SHALL immediately force IDLE, cyc_o/stb_o/we_o/res_valid_o/err_o=0, adr_o/dat_o/res_chan_o/res_data_o=0, pending/clear_mask/watchdog=0.
REQ-025 Reset mid-transfer SHALL drop cyc_o asynchronously; no status clear is issued afterwards.

Configuration
REQ-026 Macro FREQMETER_READER_TIMEOUT_EN defined: watchdog counts cycles with cyc_o=1 and ack_i=0; on reaching TIMEOUT drop cyc_o/stb_o, pulse err_o, go to IDLE (pending discarded, no WR_CLR).
REQ-027 Macro undefined: no watchdog logic; accesses wait indefinitely; err_o tied 0.

Structure
REQ-028 Shared package freqmeter_pkg SHALL hold N_CH default, STATUS_ADR/RES_BASE defaults, FSM state enum, 11-bit address type.
REQ-029 Lowest-set-bit selection SHALL be sub-module freqmeter_chan_scan (N_CH mask in, 5-bit index + any-set out, combinational).

Verification
REQ-030 Status=0x000005, ack after 1 cycle -> reads 0x000 then 0x002, stream (0,D0),(2,D2), write 0x000005 to 0x7FF, back to IDLE.
REQ-031 Status=0 with inta_i pulse -> single read of 0x7FF, no stream output, no write.
REQ-032 res_ready_i low 10 cycles during PUSH -> res_valid_o/data stable 10 cycles, no cyc_o until handshake.
REQ-033 Status=0xFFFFFFFF, N_CH=24 -> 24 results chan 0..23, clear write data 0x00FFFFFF.
REQ-034 rst_ni low during RD_RES -> cyc_o=0 same cycle, all outputs zero, IDLE after release.
REQ-035 With FREQMETER_READER_TIMEOUT_EN, TIMEOUT=255, ack_i never asserted -> cyc_o drops after 255 cycles, err_o one-cycle pulse, IDLE.
